// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit: addresses, funct3
// encodings, bit indices, interrupt cause codes and redirect FSM states.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_e;

  localparam int unsigned BIT_MIE   = 3;
  localparam int unsigned BIT_MPIE  = 7;
  localparam int unsigned BIT_MTIE  = 7;
  localparam int unsigned BIT_MEIE  = 11;
  localparam int unsigned PLAT_BASE = 16;

  localparam logic [4:0] CAUSE_MTI       = 5'd7;
  localparam logic [4:0] CAUSE_MEI       = 5'd11;
  localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

  typedef enum logic {RUN, REDIR} fsm_e;

  // Implemented mie/mip bits for a given platform line count
  function automatic logic [31:0] irq_mask(input int unsigned nplat);
    logic [31:0] m;
    m = '0;
    m[BIT_MTIE] = 1'b1;
    m[BIT_MEIE] = 1'b1;
    for (int unsigned i = 0; i < nplat; i++) m[PLAT_BASE+i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_mmode_unit_if.sv
// CSR access bus and fetch-redirect handshake between the core and csr_mmode_unit.
interface csr_mmode_unit_if #(parameter int unsigned DW = 32);
  logic [11:0]   csr_addr_i;
  logic [2:0]    csr_op_i;
  logic [DW-1:0] csr_wdata_i;
  logic [DW-1:0] csr_rdata_o;
  logic          csr_illegal_o;
  logic          redirect_ack_i;
  logic          trap_o;
  logic [DW-1:0] trap_pc_o;

  modport master (
    output csr_addr_i, csr_op_i, csr_wdata_i, redirect_ack_i,
    input  csr_rdata_o, csr_illegal_o, trap_o, trap_pc_o
  );

  modport slave (
    input  csr_addr_i, csr_op_i, csr_wdata_i, redirect_ack_i,
    output csr_rdata_o, csr_illegal_o, trap_o, trap_pc_o
  );
endinterface

// File: rtl/csr_intr_arb.sv
// Fixed-priority interrupt arbiter: MEI > MTI > plat[0] > ... > plat[NPLAT-1].
module csr_intr_arb
  import csr_pkg::*;
#(
  parameter int unsigned NPLAT = 4
) (
  input  logic [31:0] pending,
  output logic        valid,
  output logic [4:0]  cause
);

  localparam logic [31:0] MASK = irq_mask(NPLAT);

  logic unused_pend;
  assign unused_pend = ^(pending & ~MASK);

  // Walk from lowest to highest priority so later hits override earlier ones
  always_comb begin
    valid = 1'b0;
    cause = '0;
    for (int i = int'(NPLAT) - 1; i >= 0; i--) begin
      if (pending[PLAT_BASE+i]) begin
        valid = 1'b1;
        cause = 5'(int'(CAUSE_PLAT_BASE) + i);
      end
    end
    if (pending[BIT_MTIE]) begin
      valid = 1'b1;
      cause = CAUSE_MTI;
    end
    if (pending[BIT_MEIE]) begin
      valid = 1'b1;
      cause = CAUSE_MEI;
    end
  end

endmodule

// File: rtl/csr_mmode_unit.sv
// Machine-mode CSR file with interrupt take and trap/mret fetch redirect.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_mmode_unit
  import csr_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned NPLAT     = 4,
  parameter logic [31:0] RST_MTVEC = 32'h0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  csr_mmode_unit_if.slave                     bus,
  input  logic                                instr_valid_i,
  input  logic [DW-1:0]                       pc_i,
  input  logic                                is_mret_i,
  input  logic                                t_intr_i,
  input  logic                                e_intr_i,
  input  logic [((NPLAT == 0) ? 1 : NPLAT)-1:0] plat_intr_i
);

  if (DW != 32) begin : g_dw_chk
    $error("csr_mmode_unit supports DW = 32 only");
  end
  if (NPLAT > 16) begin : g_nplat_chk
    $error("csr_mmode_unit supports at most 16 platform interrupts");
  end

  localparam logic [31:0] MIE_MASK = irq_mask(NPLAT);

  fsm_e        state_q;
  logic        trap_q;
  logic [31:0] trap_pc_q;
  logic        mst_mie_q, mst_mpie_q;
  logic [31:0] mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mscratch_q;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`endif

  logic [31:0] rdata, wval, mip_nxt, tvec_base, trap_tgt;
  logic        hit, we, take, mret_go, arb_valid;
  logic [4:0]  arb_cause;

  csr_intr_arb #(.NPLAT(NPLAT)) u_arb (
    .pending (mip_q & mie_q),
    .valid   (arb_valid),
    .cause   (arb_cause)
  );

  // Read mux: returns the pre-write value of the addressed CSR
  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (bus.csr_addr_i)
      ADDR_MSTATUS: begin
        rdata[12:11]    = 2'b11;
        rdata[BIT_MPIE] = mst_mpie_q;
        rdata[BIT_MIE]  = mst_mie_q;
      end
      ADDR_MIE:      rdata = mie_q;
      ADDR_MIP:      rdata = mip_q;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:    rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:   rdata = mcycle_q[63:32];
      ADDR_MINSTRET:  rdata = minstret_q[31:0];
      ADDR_MINSTRETH: rdata = minstret_q[63:32];
`endif
      default:       hit = 1'b0;
    endcase
  end

  assign take    = instr_valid_i && mst_mie_q && arb_valid && (state_q == RUN);
  assign mret_go = instr_valid_i && is_mret_i && (state_q == RUN) && !take;

  // Write value and enable; a trap or an active redirect suppresses the write
  always_comb begin
    wval = bus.csr_wdata_i;
    we   = 1'b0;
    case (bus.csr_op_i)
      CSR_RW, CSR_RWI: begin
        wval = bus.csr_wdata_i;
        we   = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        wval = rdata | bus.csr_wdata_i;
        we   = |bus.csr_wdata_i;
      end
      CSR_RC, CSR_RCI: begin
        wval = rdata & ~bus.csr_wdata_i;
        we   = |bus.csr_wdata_i;
      end
      default: we = 1'b0;
    endcase
    if (!hit || (state_q != RUN) || take) we = 1'b0;
  end

  always_comb begin
    mip_nxt = '0;
    mip_nxt[BIT_MTIE] = t_intr_i;
    mip_nxt[BIT_MEIE] = e_intr_i;
    for (int unsigned i = 0; i < NPLAT; i++) mip_nxt[PLAT_BASE+i] = plat_intr_i[i];
  end

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign trap_tgt  = (mtvec_q[1:0] == 2'b01) ? tvec_base + (32'(arb_cause) << 2) : tvec_base;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= RST_MTVEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
    end else begin
      mip_q <= mip_nxt;
      if (we) begin
        case (bus.csr_addr_i)
          ADDR_MSTATUS: begin
            mst_mie_q  <= wval[BIT_MIE];
            mst_mpie_q <= wval[BIT_MPIE];
          end
          ADDR_MIE:      mie_q      <= wval & MIE_MASK;
          ADDR_MTVEC:    mtvec_q    <= {wval[31:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
          ADDR_MEPC:     mepc_q     <= {wval[31:2], 2'b00};
          ADDR_MCAUSE:   mcause_q   <= wval;
          ADDR_MSCRATCH: mscratch_q <= wval;
          default: ;
        endcase
      end
      case (state_q)
        RUN: begin
          if (take) begin
            mepc_q     <= (pc_i + 32'd4) & ~32'h3;
            mcause_q   <= 32'h8000_0000 | 32'(arb_cause);
            mst_mpie_q <= mst_mie_q;
            mst_mie_q  <= 1'b0;
            trap_pc_q  <= trap_tgt;
            trap_q     <= 1'b1;
            state_q    <= REDIR;
          end else if (mret_go) begin
            mst_mie_q  <= mst_mpie_q;
            mst_mpie_q <= 1'b1;
            trap_pc_q  <= mepc_q;
            trap_q     <= 1'b1;
            state_q    <= REDIR;
          end
        end
        REDIR: begin
          if (bus.redirect_ack_i) begin
            trap_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A software write to either half takes precedence over that cycle's increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (we && bus.csr_addr_i == ADDR_MCYCLE)       mcycle_q[31:0]  <= wval;
      else if (we && bus.csr_addr_i == ADDR_MCYCLEH) mcycle_q[63:32] <= wval;
      else                                           mcycle_q        <= mcycle_q + 64'd1;
      if (we && bus.csr_addr_i == ADDR_MINSTRET)       minstret_q[31:0]  <= wval;
      else if (we && bus.csr_addr_i == ADDR_MINSTRETH) minstret_q[63:32] <= wval;
      else if (instr_valid_i)                          minstret_q        <= minstret_q + 64'd1;
    end
  end
`endif

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = !hit && (bus.csr_op_i != CSR_NONE);
  assign bus.trap_o        = trap_q;
  assign bus.trap_pc_o     = trap_pc_q;

endmodule
